// File: rtl/fir_host_pkg.sv
// Shared definitions for the FIR host bridge: FSM state encoding, Wishbone
// window offsets and the read-data value returned when a handshake times out.
package fir_host_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLwr,
      StLrdA,
      StLrdD,
      StSpush,
      StSpop,
      StAck
   } state_e;

   // Offsets inside the 256-byte Wishbone window
   localparam logic [7:0] OFS_SS_PUSH = 8'h80;
   localparam logic [7:0] OFS_SM_POP  = 8'h84;
   localparam logic [7:0] OFS_SS_LAST = 8'h88;
   localparam logic [7:0] OFS_STATUS  = 8'h8C;
   // Offsets below this map straight onto the AXI-Lite register space
   localparam logic [7:0] LITE_LIMIT  = 8'h80;

   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/fir_host_bridge_if.sv
// Bundle of every bus the FIR host bridge touches: the Wishbone slave port
// from the management core, the AXI-Lite write/read channels (no B channel)
// and the ss/sm AXI-Stream channels of the FIR.
//   master : view of the bridge (responds on Wishbone, initiates AXI)
//   slave  : view of the environment (Wishbone host plus FIR responder)
interface fir_host_bridge_if #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32
);

   // Wishbone
   logic                   wbs_cyc_i;
   logic                   wbs_stb_i;
   logic                   wbs_we_i;
   logic [3:0]             wbs_sel_i;
   logic [31:0]            wbs_adr_i;
   logic [pDATA_WIDTH-1:0] wbs_dat_i;
   logic                   wbs_ack_o;
   logic [pDATA_WIDTH-1:0] wbs_dat_o;
   // AXI-Lite
   logic                   awvalid;
   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   awready;
   logic                   wvalid;
   logic [pDATA_WIDTH-1:0] wdata;
   logic                   wready;
   logic                   arvalid;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   arready;
   logic                   rvalid;
   logic [pDATA_WIDTH-1:0] rdata;
   logic                   rready;
   // AXI-Stream into (ss) and out of (sm) the FIR
   logic                   ss_tvalid;
   logic [pDATA_WIDTH-1:0] ss_tdata;
   logic                   ss_tlast;
   logic                   ss_tready;
   logic                   sm_tvalid;
   logic [pDATA_WIDTH-1:0] sm_tdata;
   logic                   sm_tlast;
   logic                   sm_tready;

   modport master (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata,
      output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
      input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
   );

   modport slave (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata,
      input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
      output ss_tready, sm_tvalid, sm_tdata, sm_tlast
   );

endinterface

// File: rtl/fir_host_bridge.sv
// Converts single Wishbone transactions from the management core into one
// AXI-Lite register access or one AXI-Stream beat towards the FIR.
//   axis_clk : sole clock for Wishbone and AXI
//   axis_rst : asynchronous active-high reset (shared with the FIR)
//   bus      : fir_host_bridge_if.master -- Wishbone slave, AXI-Lite master,
//              ss master, sm slave
// Every accepted request ends in ACK; waits are bounded by pTIMEOUT cycles.
module fir_host_bridge
   import fir_host_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter logic [31:0] pBASE       = 32'h3000_0000,
   parameter int unsigned pTIMEOUT    = 255
) (
   input logic               axis_clk,
   input logic               axis_rst,
   fir_host_bridge_if.master bus
);

   localparam int unsigned CntW = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;

   state_e                 state_q, state_d;
   logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [pDATA_WIDTH-1:0] wdata_q, wdata_d, ss_tdata_q, ss_tdata_d, dat_q, dat_d;
   logic                   ss_tlast_q, ss_tlast_d;
   logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [1:0]             status_q, status_d;
   logic [CntW-1:0]        cnt_q, cnt_d;

   logic [7:0] ofs;
   logic       req, ack;
   logic       hs_done, waiting, expire;
   logic       unused_sel;

   assign ofs        = bus.wbs_adr_i[7:0];
   assign req        = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:8] == pBASE[31:8]);
   // FIR registers are full-word; byte selects carry no information
   assign unused_sel = ^bus.wbs_sel_i;

   // Completion of the handshake the current wait state is waiting for
   always_comb begin
      hs_done = 1'b0;
      waiting = 1'b1;
      unique case (state_q)
         StLwr:   hs_done = (aw_done_q | bus.awready) & (w_done_q | bus.wready);
         StLrdA:  hs_done = bus.arready;
         StLrdD:  hs_done = bus.rvalid;
         StSpush: hs_done = bus.ss_tready;
         StSpop:  hs_done = bus.sm_tvalid;
         default: waiting = 1'b0;
      endcase
      // Handshake wins over a timeout landing in the same cycle
      expire = waiting & ~hs_done & (cnt_q == CntW'(pTIMEOUT - 1));
   end

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (ofs < LITE_LIMIT)                                       state_d = bus.wbs_we_i ? StLwr : StLrdA;
               else if (bus.wbs_we_i && (ofs == OFS_SS_PUSH || ofs == OFS_SS_LAST)) state_d = StSpush;
               else if (!bus.wbs_we_i && ofs == OFS_SM_POP)                state_d = StSpop;
               else                                                        state_d = StAck;
            end
         end
         StLrdA: begin
            if (hs_done)     state_d = StLrdD;
            else if (expire) state_d = StAck;
         end
         StLwr, StLrdD, StSpush, StSpop: begin
            if (hs_done || expire) state_d = StAck;
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.awvalid   = (state_q == StLwr) & ~aw_done_q;
      bus.wvalid    = (state_q == StLwr) & ~w_done_q;
      bus.arvalid   = state_q == StLrdA;
      bus.rready    = state_q == StLrdD;
      bus.ss_tvalid = state_q == StSpush;
      bus.sm_tready = state_q == StSpop;
      // The host may have abandoned the cycle; then the ack is swallowed
      ack           = (state_q == StAck) & bus.wbs_cyc_i & bus.wbs_stb_i;
      bus.wbs_ack_o = ack;
      bus.wbs_dat_o = ack ? dat_q : '0;
      bus.awaddr    = awaddr_q;
      bus.wdata     = wdata_q;
      bus.araddr    = araddr_q;
      bus.ss_tdata  = ss_tdata_q;
      bus.ss_tlast  = ss_tlast_q;
   end

   always_comb begin
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      ss_tdata_d = ss_tdata_q;
      ss_tlast_d = ss_tlast_q;
      dat_d      = dat_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      status_d   = status_q;
      // Restarts on every state change, so each wait state gets a full budget
      cnt_d      = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               dat_d     = '0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (ofs < LITE_LIMIT) begin
                  if (bus.wbs_we_i) begin
                     awaddr_d = bus.wbs_adr_i[pADDR_WIDTH-1:0];
                     wdata_d  = bus.wbs_dat_i;
                  end else begin
                     araddr_d = bus.wbs_adr_i[pADDR_WIDTH-1:0];
                  end
               end else if (bus.wbs_we_i && (ofs == OFS_SS_PUSH || ofs == OFS_SS_LAST)) begin
                  ss_tdata_d = bus.wbs_dat_i;
                  ss_tlast_d = ofs == OFS_SS_LAST;
               end else if (ofs == OFS_STATUS) begin
                  if (bus.wbs_we_i) status_d = '0;
                  else              dat_d    = pDATA_WIDTH'(status_q);
               end
            end
         end
         StLwr: begin
            aw_done_d = aw_done_q | bus.awready;
            w_done_d  = w_done_q | bus.wready;
         end
         StLrdD: begin
            if (bus.rvalid) dat_d = bus.rdata;
         end
         StSpop: begin
            if (bus.sm_tvalid) begin
               dat_d       = bus.sm_tdata;
               status_d[0] = bus.sm_tlast;
            end
         end
         default: ;
      endcase
      if (expire) begin
         dat_d       = pDATA_WIDTH'(TIMEOUT_DATA);
         status_d[1] = 1'b1;
      end
   end

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         ss_tdata_q <= '0;
         ss_tlast_q <= 1'b0;
         dat_q      <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         status_q   <= '0;
         cnt_q      <= '0;
      end else begin
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         ss_tdata_q <= ss_tdata_d;
         ss_tlast_q <= ss_tlast_d;
         dat_q      <= dat_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         status_q   <= status_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fir_host_bridge.sv
// Directed bench for fir_host_bridge. Each Wishbone transaction pushes its
// expected read data and ack latency to a scoreboard; the entry is popped and
// compared when the ack appears. Responder tasks play the FIR side with a
// programmable delay; a posedge monitor counts handshakes and valid cycles.
module tb_fir_host_bridge;
   import fir_host_pkg::*;

   localparam int unsigned TO    = 255;
   localparam int          BOUND = 400;
   localparam int CH_AW = 0, CH_W = 1, CH_AR = 2, CH_R = 3, CH_SS = 4, CH_SM = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_host_bridge_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

   fir_host_bridge #(
      .pADDR_WIDTH(12),
      .pDATA_WIDTH(32),
      .pBASE      (32'h3000_0000),
      .pTIMEOUT   (TO)
   ) dut (
      .axis_clk(clk),
      .axis_rst(rst),
      .bus     (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] dat;
      int          lat;  // -1: latency not checked
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Monitor: sees exactly what the DUT samples at each posedge
   int          aw_hs_n = 0, w_hs_n = 0, ss_hs_n = 0;
   int          aw_hi_n = 0, w_hi_n = 0, r_hi_n = 0, sm_hi_n = 0;
   logic [11:0] aw_cap = '0;
   logic [31:0] w_cap = '0, ss_cap = '0;
   logic        ss_last_cap = 1'b0;

   always @(posedge clk) begin
      if (bus.awvalid)   aw_hi_n <= aw_hi_n + 1;
      if (bus.wvalid)    w_hi_n  <= w_hi_n + 1;
      if (bus.rready)    r_hi_n  <= r_hi_n + 1;
      if (bus.sm_tready) sm_hi_n <= sm_hi_n + 1;
      if (bus.awvalid && bus.awready) begin
         aw_hs_n <= aw_hs_n + 1;
         aw_cap  <= bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
         w_hs_n <= w_hs_n + 1;
         w_cap  <= bus.wdata;
      end
      if (bus.ss_tvalid && bus.ss_tready) begin
         ss_hs_n     <= ss_hs_n + 1;
         ss_cap      <= bus.ss_tdata;
         ss_last_cap <= bus.ss_tlast;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic dut_vld(input int ch);
      case (ch)
         CH_AW:   return bus.awvalid;
         CH_W:    return bus.wvalid;
         CH_AR:   return bus.arvalid;
         CH_R:    return bus.rready;
         CH_SS:   return bus.ss_tvalid;
         default: return bus.sm_tready;
      endcase
   endfunction

   task automatic drive(input int ch, input logic v, input logic [31:0] d, input logic l);
      case (ch)
         CH_AW: bus.awready = v;
         CH_W:  bus.wready  = v;
         CH_AR: bus.arready = v;
         CH_R: begin
            bus.rvalid = v;
            bus.rdata  = d;
         end
         CH_SS: bus.ss_tready = v;
         default: begin
            bus.sm_tvalid = v;
            bus.sm_tdata  = d;
            bus.sm_tlast  = l;
         end
      endcase
   endtask

   // Wait for the DUT side to assert, hold off dly cycles, then one-cycle pulse
   task automatic respond(input int ch, input int dly, input logic [31:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!dut_vld(ch) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      repeat (dly) @(negedge clk);
      drive(ch, 1'b1, d, l);
      @(negedge clk);
      drive(ch, 1'b0, 32'h0, 1'b0);
   endtask

   // Called at a negedge; latency counts posedges from request to ack
   task automatic wb_txn(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] exp_dat, input int exp_lat);
      exp_t e;
      int   lat = 0;
      logic got = 1'b0;
      logic [31:0] dat = '0;
      e.tag = tag;
      e.dat = exp_dat;
      e.lat = exp_lat;
      sb.push_back(e);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wd;
      while (!got && lat < BOUND) begin
         @(negedge clk);
         lat++;
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            dat = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      e = sb.pop_front();
      check({e.tag, "_ack"}, 32'(got), 32'd1);
      if (got) begin
         check({e.tag, "_dat"}, dat, e.dat);
         if (e.lat >= 0) check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
      end
   endtask

   int aw0, w0, ss0, awh0, wh0, rh0, smh0, acks;

   initial begin
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b0; bus.rdata = '0; bus.ss_tready = 1'b0;
      bus.sm_tvalid = 1'b0; bus.sm_tdata = '0; bus.sm_tlast = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", {24'h0, bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                         bus.ss_tvalid, bus.sm_tready, bus.wbs_ack_o, bus.ss_tlast}, 32'h0);
      check("rst_dat_o", bus.wbs_dat_o, 32'h0);
      check("rst_addr", {8'h0, bus.awaddr, bus.araddr}, 32'h0);
      check("rst_wdata", bus.wdata, 32'h0);
      check("rst_ss_tdata", bus.ss_tdata, 32'h0);
      rst = 1'b0;

      // Lite write, immediate handshakes
      @(negedge clk);
      aw0 = aw_hs_n; w0 = w_hs_n; awh0 = aw_hi_n; wh0 = w_hi_n;
      fork
         wb_txn("lwr", 1'b1, 32'h3000_0010, 32'h5, 32'h0, 2);
         respond(CH_AW, 0, 32'h0, 1'b0);
         respond(CH_W, 0, 32'h0, 1'b0);
      join
      check("lwr_aw_hs", 32'(aw_hs_n - aw0), 32'd1);
      check("lwr_w_hs", 32'(w_hs_n - w0), 32'd1);
      check("lwr_awaddr", {20'h0, aw_cap}, 32'h010);
      check("lwr_wdata", w_cap, 32'h5);
      check("lwr_aw_cycles", 32'(aw_hi_n - awh0), 32'd1);
      check("lwr_w_cycles", 32'(w_hi_n - wh0), 32'd1);

      // Lite write, wready three cycles after awready
      @(negedge clk);
      awh0 = aw_hi_n; wh0 = w_hi_n; aw0 = aw_hs_n; w0 = w_hs_n;
      fork
         wb_txn("lwr_split", 1'b1, 32'h3000_0000, 32'h1, 32'h0, 5);
         respond(CH_AW, 0, 32'h0, 1'b0);
         respond(CH_W, 3, 32'h0, 1'b0);
      join
      check("split_aw_cycles", 32'(aw_hi_n - awh0), 32'd1);
      check("split_w_cycles", 32'(w_hi_n - wh0), 32'd4);
      check("split_hs", 32'((aw_hs_n - aw0) + (w_hs_n - w0)), 32'd2);

      // Lite read, rvalid four cycles into the data phase
      @(negedge clk);
      rh0 = r_hi_n;
      fork
         wb_txn("lrd", 1'b0, 32'h3000_0000, 32'h0, 32'h4, 7);
         respond(CH_AR, 0, 32'h0, 1'b0);
         respond(CH_R, 4, 32'h4, 1'b0);
      join
      check("lrd_rready_cycles", 32'(r_hi_n - rh0), 32'd5);

      // Stream push with tlast, then pop and status
      @(negedge clk);
      ss0 = ss_hs_n;
      fork
         wb_txn("push_last", 1'b1, 32'h3000_0088, 32'h7, 32'h0, 4);
         respond(CH_SS, 2, 32'h0, 1'b0);
      join
      check("push_hs", 32'(ss_hs_n - ss0), 32'd1);
      check("push_tdata", ss_cap, 32'h7);
      check("push_tlast", 32'(ss_last_cap), 32'd1);
      @(negedge clk);
      fork
         wb_txn("pop", 1'b0, 32'h3000_0084, 32'h0, 32'h23, 2);
         respond(CH_SM, 0, 32'h23, 1'b1);
      join
      @(negedge clk);
      wb_txn("status_last", 1'b0, 32'h3000_008C, 32'h0, 32'h1, 1);

      // Pop timeout, sticky status bit, status clear
      @(negedge clk);
      smh0 = sm_hi_n;
      wb_txn("pop_timeout", 1'b0, 32'h3000_0084, 32'h0, TIMEOUT_DATA, 256);
      check("pop_timeout_tready_cycles", 32'(sm_hi_n - smh0), 32'(TO));
      @(negedge clk);
      wb_txn("status_to", 1'b0, 32'h3000_008C, 32'h0, 32'h3, 1);
      @(negedge clk);
      wb_txn("status_clr", 1'b1, 32'h3000_008C, 32'h0, 32'h0, 1);
      @(negedge clk);
      wb_txn("status_zero", 1'b0, 32'h3000_008C, 32'h0, 32'h0, 1);

      // Unmapped offset reads zero; out-of-window requests get no ack
      @(negedge clk);
      wb_txn("unmapped", 1'b0, 32'h3000_0090, 32'h0, 32'h0, 1);
      @(negedge clk);
      awh0 = aw_hi_n;
      acks = 0;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_adr_i = 32'h4000_0010; bus.wbs_dat_i = 32'h9;
      repeat (8) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      check("oow_noack", 32'(acks), 32'd0);
      check("oow_no_aw", 32'(aw_hi_n - awh0), 32'd0);

      // Reset while a push is pending
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_adr_i = 32'h3000_0080; bus.wbs_dat_i = 32'hAA;
      @(negedge clk);
      check("rst_mid_pending", 32'(bus.ss_tvalid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_drop", 32'(bus.ss_tvalid), 32'd0);
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
      end
      check("rst_mid_noack", 32'(acks), 32'd0);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ss0 = ss_hs_n;
      fork
         wb_txn("post_rst_push", 1'b1, 32'h3000_0080, 32'h9, 32'h0, 2);
         respond(CH_SS, 0, 32'h0, 1'b0);
      join
      check("post_rst_hs", 32'(ss_hs_n - ss0), 32'd1);
      check("post_rst_tdata", ss_cap, 32'h9);
      check("post_rst_tlast", 32'(ss_last_cap), 32'd0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
